// File: rtl/soc_ctrl_pkg.sv
// Shared opcode, FSM-state and reply-byte constants for the SoC test sequencer.
package soc_ctrl_pkg;

  localparam logic [7:0] OP_CLK_OFF   = 8'h00;
  localparam logic [7:0] OP_CLK_ON    = 8'h01;
  localparam logic [7:0] OP_RST_PULSE = 8'h02;
  localparam logic [7:0] OP_RST_REL   = 8'h03;
  localparam logic [7:0] OP_SEL_SOC   = 8'h04;
  localparam logic [7:0] OP_SEL_CTRL  = 8'h05;
  localparam logic [7:0] OP_RX_PASS   = 8'h06;
  localparam logic [7:0] OP_RX_BLOCK  = 8'h07;
  localparam logic [7:0] OP_STATUS    = 8'h08;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RST_HOLD = 2'd1;
  localparam logic [1:0] S_SW_WAIT  = 2'd2;
  localparam logic [1:0] S_REPLY    = 2'd3;

  localparam logic [3:0] STATUS_SIG = 4'hA;
  localparam logic [7:0] ACK_BIT    = 8'h80;
  localparam logic [7:0] NAK_BYTE   = 8'hFF;

  function automatic logic [7:0] make_status(input logic rx_block, input logic sel_tx_ctrl,
                                             input logic soc_reset, input logic soc_clk_en);
    return {STATUS_SIG, rx_block, sel_tx_ctrl, soc_reset, soc_clk_en};
  endfunction

endpackage

// File: rtl/line_idle_detector.sv
// Counts consecutive idle-high cycles of a serial line, saturating at GUARD_CYCLES.
module line_idle_detector #(
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic line,
  output logic idle
);

  localparam int unsigned CNT_W = $clog2(GUARD_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || !line) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_W'(GUARD_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign idle = (idle_cnt == CNT_W'(GUARD_CYCLES));

endmodule

// File: rtl/soc_test_sequencer.sv
// Host-UART command sequencer: SoC clock gate, timed SoC reset, RX gating, serial_tx mux.
// Optional feature: define SOC_SEQ_ACK_EN to generate ack/NAK replies for opcodes 0x00-0x07.
module soc_test_sequencer
  import soc_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 50,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       soc_tx,
  output logic       soc_clk_en,
  output logic       soc_reset,
  output logic       sel_tx_ctrl,
  output logic       rx_block,
  output logic       led_n,
  output logic       cmd_drop
);

  localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);

  logic [1:0]       state;
  logic [RST_W-1:0] rst_cnt;
  logic [7:0]       reply_byte;
  logic             idle_clear;
  logic             line_idle;
  logic             sw_needed;
  logic             sw_go;

  assign idle_clear = (state != S_SW_WAIT);

  line_idle_detector #(.GUARD_CYCLES(GUARD_CYCLES)) u_idle (
    .clk   (clk),
    .reset (reset),
    .clear (idle_clear),
    .line  (soc_tx),
    .idle  (line_idle)
  );

  // A select request only waits when it would actually change the mux.
  assign sw_needed = ((rx_data == OP_SEL_SOC) || (rx_data == OP_SEL_CTRL)) &&
                     (sel_tx_ctrl != rx_data[0]);
  assign sw_go     = (line_idle || !soc_clk_en) && !tx_busy;
  assign led_n     = ~soc_reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      reply_byte  <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      soc_clk_en  <= 1'b1;
      soc_reset   <= 1'b0;
      sel_tx_ctrl <= 1'b0;
      rx_block    <= 1'b0;
      cmd_drop    <= 1'b0;
    end else begin
      tx_en    <= 1'b0;
      cmd_drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              OP_CLK_OFF:   soc_clk_en <= 1'b0;
              OP_CLK_ON:    soc_clk_en <= 1'b1;
              OP_RX_PASS:   rx_block   <= 1'b0;
              OP_RX_BLOCK:  rx_block   <= 1'b1;
              OP_RST_REL:   soc_reset  <= 1'b0;
              OP_RST_PULSE: begin
                soc_reset <= 1'b1;
                rst_cnt   <= RST_W'(1);
                state     <= S_RST_HOLD;
              end
              OP_SEL_SOC, OP_SEL_CTRL: begin
                if (sw_needed) state <= S_SW_WAIT;
              end
              OP_STATUS: begin
                reply_byte <= make_status(rx_block, sel_tx_ctrl, soc_reset, soc_clk_en);
                state      <= S_REPLY;
              end
              default: ;
            endcase
`ifdef SOC_SEQ_ACK_EN
            // Reset pulse and select-with-wait ack on completion, not here.
            if ((rx_data != OP_RST_PULSE) && (rx_data != OP_STATUS)) begin
              reply_byte <= (rx_data <= OP_RX_BLOCK) ? (ACK_BIT | rx_data) : NAK_BYTE;
              if (!sw_needed) state <= S_REPLY;
              else            state <= S_SW_WAIT;
            end
`endif
          end
        end

        S_RST_HOLD: begin
          if (rx_valid && (rx_data == OP_RST_REL)) begin
            soc_reset <= 1'b0;
            rst_cnt   <= '0;
            state     <= S_IDLE;
`ifdef SOC_SEQ_ACK_EN
            reply_byte <= ACK_BIT | OP_RST_REL;
            state      <= S_REPLY;
`endif
          end else begin
            if (rx_valid) cmd_drop <= 1'b1;
            if (rst_cnt == RST_W'(RESET_CYCLES)) begin
              soc_reset <= 1'b0;
              rst_cnt   <= '0;
              state     <= S_IDLE;
`ifdef SOC_SEQ_ACK_EN
              reply_byte <= ACK_BIT | OP_RST_PULSE;
              state      <= S_REPLY;
`endif
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
        end

        S_SW_WAIT: begin
          if (rx_valid) cmd_drop <= 1'b1;
          if (sw_go) begin
            sel_tx_ctrl <= ~sel_tx_ctrl;
`ifdef SOC_SEQ_ACK_EN
            state       <= S_REPLY;
`else
            state       <= S_IDLE;
`endif
          end
        end

        S_REPLY: begin
          if (rx_valid) cmd_drop <= 1'b1;
          if (!tx_busy) begin
            // With the mux on the SoC the byte could never reach the host.
            if (sel_tx_ctrl) begin
              tx_en   <= 1'b1;
              tx_data <= reply_byte;
            end
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
